// File: rtl/biquad_pkg.sv
// Shared types and helpers for the biquad cascade: coefficient slot enum,
// FSM state enum, tap/cycle constants and the saturating narrow function.
package biquad_pkg;

    localparam int TAPS        = 5;
    localparam int CYC_PER_SEC = 6;
    localparam int CLAMP_W     = 128;

    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_idx_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        UPD  = 2'd2,
        HOLD = 2'd3
    } state_e;

    // Clamp a wide signed value to the range of a w-bit signed number.
    function automatic logic signed [CLAMP_W-1:0] clamp_to_width(
        input logic signed [CLAMP_W-1:0] v,
        input int                        w
    );
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        hi = CLAMP_W'(1);
        hi = (hi <<< (w - 1)) - CLAMP_W'(1);
        lo = -hi - CLAMP_W'(1);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/biquad_cascade_if.sv
// Sample stream, coefficient write port and status of the biquad cascade.
interface biquad_cascade_if #(
    parameter int WIDTH        = 24,
    parameter int COEF_W       = 32,
    parameter int NUM_SECTIONS = 2
);
    localparam int AW = $clog2(5 * NUM_SECTIONS);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [WIDTH-1:0]  sample_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [WIDTH-1:0]  sample_out;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     hist_clr_in;
    logic                     busy;

    modport master (
        output in_valid, sample_in, out_ready, coef_we, coef_addr, coef_data, hist_clr_in,
        input  in_ready, out_valid, sample_out, busy
    );

    modport slave (
        input  in_valid, sample_in, out_ready, coef_we, coef_addr, coef_data, hist_clr_in,
        output in_ready, out_valid, sample_out, busy
    );

endinterface

// File: rtl/biquad_mac.sv
// Shared multiply-accumulator: one signed product per enabled cycle, added to
// or subtracted from the running sum; clr restarts the sum with this product.
module biquad_mac #(
    parameter int WIDTH  = 24,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic                     sub_i,
    input  logic signed [WIDTH-1:0]  operand_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [ACC_W-1:0]  acc_o
);
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] base;

    // Next accumulator value from the current product.
    always_comb begin
        prod  = ACC_W'(operand_i) * ACC_W'(coef_i);
        base  = clr_i ? '0 : acc_q;
        acc_d = acc_q;
        if (en_i) begin
            acc_d = sub_i ? (base - prod) : (base + prod);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/biquad_cascade.sv
// Cascade of Direct-Form-I biquads sharing one MAC. Each section takes five
// MAC cycles plus one writeback cycle; the result is held until taken.
// Build option BIQUAD_CASCADE_SAT_EN: clamp each section result to WIDTH
// instead of wrapping.
//
// state | meaning
// IDLE  | ready for a sample; coefficient writes and history clear honoured
// MAC   | five taps b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2 for section sec
// UPD   | narrow result, shift section history, feed next section
// HOLD  | result presented on sample_out until out_ready
module biquad_cascade
    import biquad_pkg::*;
#(
    parameter int WIDTH        = 24,
    parameter int COEF_W       = 32,
    parameter int SHIFT        = 20,
    parameter int NUM_SECTIONS = 2,
    parameter int ACC_W        = 64
) (
    input  logic            clk_in,
    input  logic            rst_in,
    biquad_cascade_if.slave bus
);
    localparam int NCOEF = TAPS * NUM_SECTIONS;
    localparam int AW    = $clog2(NCOEF);
    localparam int SW    = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) <<< SHIFT;

    state_e        state_q, state_d;
    logic [SW-1:0] sec_q, sec_d;
    coef_idx_e     tap_q, tap_d;
    logic          clr_pend_q, clr_pend_d;

    logic signed [COEF_W-1:0] coef_q [NCOEF];
    logic signed [WIDTH-1:0]  x1_q [NUM_SECTIONS];
    logic signed [WIDTH-1:0]  x2_q [NUM_SECTIONS];
    logic signed [WIDTH-1:0]  y1_q [NUM_SECTIONS];
    logic signed [WIDTH-1:0]  y2_q [NUM_SECTIONS];
    logic signed [WIDTH-1:0]  x_cur_q;
    logic signed [WIDTH-1:0]  y_out_q;

    logic                     accept, last_sec, coef_wr, hist_clr, upd;
    logic                     mac_en, mac_clr, mac_sub;
    logic [AW-1:0]            cidx;
    logic signed [WIDTH-1:0]  mac_op, y_upd;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [ACC_W-1:0]  acc, acc_sh;

    assign last_sec = (sec_q == SW'(NUM_SECTIONS - 1));
    assign cidx     = AW'(int'(sec_q) * TAPS + int'(tap_q));
    assign acc_sh   = acc >>> SHIFT;

`ifdef BIQUAD_CASCADE_SAT_EN
    assign y_upd = WIDTH'(clamp_to_width(CLAMP_W'(acc_sh), WIDTH));
`else
    logic unused_acc_hi;
    assign y_upd         = acc_sh[WIDTH-1:0];
    assign unused_acc_hi = ^acc_sh[ACC_W-1:WIDTH];
`endif

    // FSM state, section/tap counters and deferred-clear flag.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            sec_q      <= '0;
            tap_q      <= B0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            tap_q      <= tap_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        tap_d   = tap_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = MAC;
                sec_d   = '0;
                tap_d   = B0;
            end
            MAC: if (tap_q == A2) begin
                state_d = UPD;
            end else begin
                tap_d = coef_idx_e'(tap_q + 3'd1);
            end
            UPD: if (last_sec) begin
                state_d = HOLD;
            end else begin
                state_d = MAC;
                sec_d   = sec_q + 1'b1;
                tap_d   = B0;
            end
            HOLD: if (bus.out_ready) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs and per-state strobes; a clear seen outside IDLE waits for IDLE.
    always_comb begin
        bus.in_ready   = (state_q == IDLE) && rst_in;
        bus.out_valid  = (state_q == HOLD);
        bus.busy       = (state_q != IDLE);
        bus.sample_out = y_out_q;
        accept         = bus.in_ready && bus.in_valid;
        coef_wr        = (state_q == IDLE) && bus.coef_we && (int'(bus.coef_addr) < NCOEF);
        hist_clr       = (state_q == IDLE) && (bus.hist_clr_in || clr_pend_q);
        clr_pend_d     = hist_clr ? 1'b0 : (clr_pend_q || bus.hist_clr_in);
        upd            = (state_q == UPD);
        mac_en         = (state_q == MAC);
        mac_clr        = (tap_q == B0);
    end

    // Operand and coefficient selection for the current tap.
    always_comb begin
        mac_op   = x_cur_q;
        mac_sub  = 1'b0;
        mac_coef = coef_q[cidx];
        case (tap_q)
            B1: mac_op = x1_q[sec_q];
            B2: mac_op = x2_q[sec_q];
            A1: begin
                mac_op  = y1_q[sec_q];
                mac_sub = 1'b1;
            end
            A2: begin
                mac_op  = y2_q[sec_q];
                mac_sub = 1'b1;
            end
            default: mac_op = x_cur_q;
        endcase
    end

    // Coefficient store; reset leaves every section as a unity pass-through.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NCOEF; i++) begin
                coef_q[i] <= ((i % TAPS) == 0) ? COEF_ONE : '0;
            end
        end else if (coef_wr) begin
            coef_q[bus.coef_addr] <= bus.coef_data;
        end
    end

    // Sample pipeline and per-section history.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
            x_cur_q <= '0;
            y_out_q <= '0;
        end else begin
            if (hist_clr) begin
                for (int i = 0; i < NUM_SECTIONS; i++) begin
                    x1_q[i] <= '0;
                    x2_q[i] <= '0;
                    y1_q[i] <= '0;
                    y2_q[i] <= '0;
                end
            end
            if (accept) begin
                x_cur_q <= bus.sample_in;
            end
            if (upd) begin
                x2_q[sec_q] <= x1_q[sec_q];
                x1_q[sec_q] <= x_cur_q;
                y2_q[sec_q] <= y1_q[sec_q];
                y1_q[sec_q] <= y_upd;
                x_cur_q     <= y_upd;
                if (last_sec) begin
                    y_out_q <= y_upd;
                end
            end
        end
    end

    biquad_mac #(
        .WIDTH (WIDTH),
        .COEF_W(COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en_i     (mac_en),
        .clr_i    (mac_clr),
        .sub_i    (mac_sub),
        .operand_i(mac_op),
        .coef_i   (mac_coef),
        .acc_o    (acc)
    );

endmodule
